// File: rtl/seg7_reader.sv
// seg7_reader: reads a time-multiplexed, active-low two-digit 7-segment bus,
// debounces each digit and converts the pair back to a 4-bit value with
// blank/error flags, delivered over a valid/ready handshake.
// Optional build macro: SEG7_READER_CHANGE_ONLY_EN (emit only results that
// differ from the last delivered one).
module seg7_reader #(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned CNT_W         = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] seg_in,
   input  logic [1:0] dig_sel,
   input  logic       out_ready,
   output logic       out_valid,
   output logic [3:0] out_value,
   output logic       out_blank,
   output logic       out_err
);

   localparam logic [1:0] S_COLLECT = 2'd0;
   localparam logic [1:0] S_EVAL    = 2'd1;
   localparam logic [1:0] S_EMIT    = 2'd2;

   localparam logic [6:0]       SEG_BLANK = 7'b1111111;
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(STABLE_CYCLES);

   logic [1:0]       state;
   logic [1:0]       state_next;
   logic [8:0]       prev_pair;
   logic [8:0]       pair;
   logic             active;
   logic             same;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic             capture;
   logic [6:0]       ones_q;
   logic [6:0]       tens_q;
   logic             got_ones;
   logic             got_tens;
   logic [3:0]       dec_value;
   logic             dec_blank;
   logic             dec_err;
   logic             suppress;

   // Pattern to {legal, digit}; blank is reported as not legal here.
   function automatic logic [4:0] seg_decode(input logic [6:0] seg);
      logic [4:0] r;
      case (seg)
         7'b0000001: r = {1'b1, 4'd0};
         7'b1001111: r = {1'b1, 4'd1};
         7'b0010010: r = {1'b1, 4'd2};
         7'b0000110: r = {1'b1, 4'd3};
         7'b1001100: r = {1'b1, 4'd4};
         7'b0100100: r = {1'b1, 4'd5};
         7'b1100000: r = {1'b1, 4'd6};
         7'b0001111: r = {1'b1, 4'd7};
         7'b0000000: r = {1'b1, 4'd8};
         7'b0001100: r = {1'b1, 4'd9};
         default:    r = {1'b0, 4'd0};
      endcase
      return r;
   endfunction

   // Stability counter and capture strobe; idle outside COLLECT.
   always_comb begin
      pair     = {dig_sel, seg_in};
      active   = (dig_sel == 2'b01) || (dig_sel == 2'b10);
      same     = (pair == prev_pair);
      cnt_next = cnt;
      capture  = 1'b0;
      if (state != S_COLLECT || !active) begin
         cnt_next = '0;
      end else if (!same) begin
         cnt_next = CNT_W'(1);
      end else if (cnt != CNT_MAX) begin
         cnt_next = cnt + CNT_W'(1);
      end
      // capture only on the step into the saturated count, not while held there
      if (state == S_COLLECT && active && cnt_next == CNT_MAX && !(same && cnt == CNT_MAX)) begin
         capture = 1'b1;
      end
   end

   // Decode the captured digit pair in priority order.
   always_comb begin
      logic [4:0] o;
      logic [4:0] t;
      logic       ob;
      logic       tb;
      logic [4:0] sum;
      dec_value = 4'd0;
      dec_blank = 1'b0;
      dec_err   = 1'b0;
      o   = seg_decode(ones_q);
      t   = seg_decode(tens_q);
      ob  = (ones_q == SEG_BLANK);
      tb  = (tens_q == SEG_BLANK);
      sum = 5'(t[3:0]) * 5'd10 + 5'(o[3:0]);
      if ((!o[4] && !ob) || (!t[4] && !tb)) begin
         dec_err = 1'b1;
      end else if (ob && tb) begin
         dec_blank = 1'b1;
      end else if (ob || tb) begin
         dec_err = 1'b1;
      end else if (t[3:0] > 4'd1) begin
         dec_err = 1'b1;
      end else if (sum > 5'd15) begin
         dec_err = 1'b1;
      end else begin
         dec_value = sum[3:0];
      end
   end

`ifdef SEG7_READER_CHANGE_ONLY_EN
   logic [5:0] last_result;
   logic       last_valid;

   // Drop a result identical to the last one handed to the consumer.
   always_comb begin
      suppress = last_valid && ({dec_value, dec_blank, dec_err} == last_result);
   end

   // Remember the most recently delivered result.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_result <= '0;
         last_valid  <= 1'b0;
      end else if (state == S_EMIT && out_valid && out_ready) begin
         last_result <= {out_value, out_blank, out_err};
         last_valid  <= 1'b1;
      end
   end
`else
   // Every completed digit pair is emitted.
   always_comb begin
      suppress = 1'b0;
   end
`endif

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         S_COLLECT: if (got_ones && got_tens) state_next = S_EVAL;
         S_EVAL:    state_next = suppress ? S_COLLECT : S_EMIT;
         S_EMIT:    if (out_valid && out_ready) state_next = S_COLLECT;
         default:   state_next = S_COLLECT;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= S_COLLECT;
      else       state <= state_next;
   end

   // Sampling, digit capture and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         prev_pair <= '0;
         cnt       <= '0;
         ones_q    <= SEG_BLANK;
         tens_q    <= SEG_BLANK;
         got_ones  <= 1'b0;
         got_tens  <= 1'b0;
         out_valid <= 1'b0;
         out_value <= 4'd0;
         out_blank <= 1'b0;
         out_err   <= 1'b0;
      end else begin
         prev_pair <= pair;
         cnt       <= cnt_next;
         if (capture) begin
            if (dig_sel == 2'b01) begin
               ones_q   <= seg_in;
               got_ones <= 1'b1;
            end else begin
               tens_q   <= seg_in;
               got_tens <= 1'b1;
            end
         end
         case (state)
            S_EVAL: begin
               if (suppress) begin
                  got_ones <= 1'b0;
                  got_tens <= 1'b0;
               end else begin
                  out_valid <= 1'b1;
                  out_value <= dec_value;
                  out_blank <= dec_blank;
                  out_err   <= dec_err;
               end
            end
            S_EMIT: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  got_ones  <= 1'b0;
                  got_tens  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seg7_reader.sv
// Directed bench for seg7_reader (STABLE_CYCLES=4). Inputs change on the
// falling edge; outputs are sampled on the falling edge.
module tb_seg7_reader;

   localparam logic [6:0] D0 = 7'b0000001;
   localparam logic [6:0] D1 = 7'b1001111;
   localparam logic [6:0] D2 = 7'b0010010;
   localparam logic [6:0] D3 = 7'b0000110;
   localparam logic [6:0] D5 = 7'b0100100;
   localparam logic [6:0] D7 = 7'b0001111;
   localparam logic [6:0] D8 = 7'b0000000;
   localparam logic [6:0] D9 = 7'b0001100;
   localparam logic [6:0] BL = 7'b1111111;
   localparam logic [6:0] BAD = 7'b1111110;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] seg_in;
   logic [1:0] dig_sel;
   logic       out_ready;
   logic       out_valid;
   logic [3:0] out_value;
   logic       out_blank;
   logic       out_err;

   int n_cmp = 0;
   int n_bad = 0;
   int vcnt  = 0;
   int xfers = 0;
   int lat;
   int v0;

   seg7_reader #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .seg_in(seg_in), .dig_sel(dig_sel),
      .out_ready(out_ready), .out_valid(out_valid), .out_value(out_value),
      .out_blank(out_blank), .out_err(out_err)
   );

   always #5 clk = ~clk;

   // Count valid cycles and completed transfers.
   always @(posedge clk) begin
      if (!reset && out_valid) vcnt <= vcnt + 1;
      if (!reset && out_valid && out_ready) xfers <= xfers + 1;
   end

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [1:0] d, input logic [6:0] s, input int n);
      dig_sel = d;
      seg_in  = s;
      repeat (n) @(negedge clk);
   endtask

   // Ones then tens, each held long enough to capture, then idle the bus.
   task automatic send(input logic [6:0] tens, input logic [6:0] ones);
      drive(2'b01, ones, 4);
      drive(2'b10, tens, 4);
      drive(2'b00, BL, 0);
   endtask

   // Falling edges until out_valid, 0 if it never arrives within max.
   task automatic wait_valid(input int max, output int l);
      int i;
      l = 0;
      i = 0;
      while (l == 0 && i < max) begin
         @(negedge clk);
         i++;
         if (out_valid) l = i;
      end
   endtask

   task automatic expect_result(input string tag, input int v, input int b, input int e);
      int l;
      wait_valid(8, l);
      check({tag, "_lat"}, l, 2);
      check({tag, "_value"}, out_value, v);
      check({tag, "_blank"}, out_blank, b);
      check({tag, "_err"}, out_err, e);
   endtask

   initial begin
      reset = 1'b1; seg_in = BL; dig_sel = 2'b00; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_valid", out_valid, 0);
      check("rst_value", out_value, 0);
      check("rst_blank", out_blank, 0);
      check("rst_err", out_err, 0);

      // 09, consumer ready: one-cycle valid pulse two cycles after capture
      out_ready = 1'b1;
      send(D0, D9);
      expect_result("v09", 9, 0, 0);
      @(negedge clk);
      check("v09_drop", out_valid, 0);

      // 12 with back-pressure
      out_ready = 1'b0;
      send(D1, D2);
      expect_result("v12", 12, 0, 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("v12_hold_valid", out_valid, 1);
         check("v12_hold_value", out_value, 12);
      end
      out_ready = 1'b1;
      v0 = xfers;
      @(negedge clk);
      check("v12_drop", out_valid, 0);
      repeat (3) @(negedge clk);
      check("v12_xfers", xfers - v0, 1);

      // 18 is out of range
      send(D1, D8);
      expect_result("v18", 0, 0, 1);
      @(negedge clk);

      // both blank
      send(BL, BL);
      expect_result("blank", 0, 1, 0);
      @(negedge clk);

      // illegal pattern on ones
      send(D0, BAD);
      expect_result("illegal", 0, 0, 1);
      @(negedge clk);

      // one digit blank
      send(D1, BL);
      expect_result("half_blank", 0, 0, 1);
      @(negedge clk);

      // toggling ones never settles, so no result despite a captured tens
      drive(2'b10, D0, 4);
      v0 = vcnt;
      for (int i = 0; i < 5; i++) begin
         drive(2'b01, D0, 2);
         drive(2'b01, D1, 2);
      end
      drive(2'b00, BL, 4);
      check("toggle_no_valid", vcnt - v0, 0);
      drive(2'b01, D1, 4);
      drive(2'b00, BL, 0);
      expect_result("after_toggle", 1, 0, 0);
      @(negedge clk);

      // reset while a result is pending
      out_ready = 1'b0;
      send(D0, D3);
      expect_result("pre_rst", 3, 0, 0);
      reset = 1'b1;
      @(negedge clk);
      check("rst_emit_valid", out_valid, 0);
      check("rst_emit_value", out_value, 0);
      reset = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_emit_stay", out_valid, 0);

`ifdef SEG7_READER_CHANGE_ONLY_EN
      // 5, 5, 7: the repeated 5 is not re-emitted
      v0 = xfers;
      send(D0, D5);
      expect_result("co5", 5, 0, 0);
      @(negedge clk);
      send(D0, D5);
      wait_valid(8, lat);
      check("co5_again_suppressed", lat, 0);
      send(D0, D7);
      expect_result("co7", 7, 0, 0);
      @(negedge clk);
      check("co_xfers", xfers - v0, 2);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
